// File: rtl/mc_fifo_pkg.sv
// Shared types and helpers for the multi-channel FIFO array.
package mc_fifo_pkg;

    localparam int MC_FIFO_LAT = 1;

    typedef struct packed {
        logic full;
        logic empty;
        logic afull;
    } mc_fifo_flags_t;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mc_fifo_ch.sv
// One circular FIFO channel: storage, pointers, occupancy and flags.
// Requests arrive already decoded; acceptance is gated here on pre-edge flags.
module mc_fifo_ch
    import mc_fifo_pkg::*;
#(
    parameter int DEPTH_LG2  = 4,
    parameter int DATA_WIDTH = 32,
    parameter bit RST_MEM    = 1'b0,
    parameter int AFULL_THR  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] head,
    output logic [DEPTH_LG2:0]    count,
    output mc_fifo_flags_t        flags
);
    localparam int DEPTH = 1 << DEPTH_LG2;
    localparam logic [DEPTH_LG2:0] FULL_CNT = {1'b1, {DEPTH_LG2{1'b0}}};
    localparam logic [DEPTH_LG2:0] THR      = AFULL_THR[DEPTH_LG2:0];

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
    logic [DEPTH_LG2-1:0] wptr, rptr;
    logic wr_acc, rd_acc;

    always_comb begin
        flags.full  = (count == FULL_CNT);
        flags.empty = (count == '0);
        flags.afull = (count >= THR);
    end

    assign wr_acc = wr_en & ~flags.full;
    assign rd_acc = rd_en & ~flags.empty;
    assign head   = mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_acc) wptr <= wptr + 1'b1;
            if (rd_acc) rptr <= rptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    if (RST_MEM) begin : g_mem_rst
        always_ff @(posedge clk or posedge rst) begin
            if (rst)         mem <= '0;
            else if (wr_acc) mem[wptr] <= wdata;
        end
    end else begin : g_mem
        always_ff @(posedge clk) begin
            if (wr_acc) mem[wptr] <= wdata;
        end
    end

endmodule

// File: rtl/mc_fifo_array.sv
// N_CH independent FIFOs behind one shared write port and one registered read port.
// Optional MC_FIFO_ERR_EN adds sticky per-channel overflow/underflow flags.
module mc_fifo_array
    import mc_fifo_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int DEPTH_LG2  = 4,
    parameter int DATA_WIDTH = 32,
    parameter bit RST_MEM    = 1'b0,
    parameter int AFULL_THR  = 12,
    localparam int CH_W      = ch_w(N_CH),
    localparam int CNT_W     = DEPTH_LG2 + 1
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef MC_FIFO_ERR_EN
    input  logic                    err_clr_i,
    output logic [N_CH-1:0]         ovf_vec_o,
    output logic [N_CH-1:0]         udf_vec_o,
`endif
    input  logic [CH_W-1:0]         wr_ch_i,
    input  logic                    wren_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    full_o,
    input  logic [CH_W-1:0]         rd_ch_i,
    input  logic                    rden_i,
    output logic                    empty_o,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic [CH_W-1:0]         rch_o,
    output logic [N_CH-1:0]         full_vec_o,
    output logic [N_CH-1:0]         empty_vec_o,
    output logic [N_CH-1:0]         afull_vec_o,
    output logic [N_CH*CNT_W-1:0]   cnt_o
);
    localparam logic [CH_W:0] N_CH_L = N_CH[CH_W:0];

    logic [N_CH-1:0] wr_en, rd_en;
    logic [N_CH-1:0][DATA_WIDTH-1:0] head;
    logic [MC_FIFO_LAT:1] vld_pipe;
    logic wr_ch_ok, rd_ch_ok, rd_acc;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        mc_fifo_flags_t flg;

        assign wr_en[c] = wren_i & (wr_ch_i == CH_W'(c));
        assign rd_en[c] = rden_i & (rd_ch_i == CH_W'(c));

        mc_fifo_ch #(
            .DEPTH_LG2 (DEPTH_LG2),
            .DATA_WIDTH(DATA_WIDTH),
            .RST_MEM   (RST_MEM),
            .AFULL_THR (AFULL_THR)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .wr_en(wr_en[c]),
            .rd_en(rd_en[c]),
            .wdata(wdata_i),
            .head (head[c]),
            .count(cnt_o[c*CNT_W +: CNT_W]),
            .flags(flg)
        );

        assign full_vec_o[c]  = flg.full;
        assign empty_vec_o[c] = flg.empty;
        assign afull_vec_o[c] = flg.afull;
    end

    // Out-of-range channel indices look full/empty so every request to them is ignored.
    assign wr_ch_ok = ({1'b0, wr_ch_i} < N_CH_L);
    assign rd_ch_ok = ({1'b0, rd_ch_i} < N_CH_L);
    assign full_o   = wr_ch_ok ? full_vec_o[wr_ch_i]  : 1'b1;
    assign empty_o  = rd_ch_ok ? empty_vec_o[rd_ch_i] : 1'b1;
    assign rd_acc   = rden_i & ~empty_o;
    assign rvalid_o = vld_pipe[MC_FIFO_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            rdata_o  <= '0;
            rch_o    <= '0;
        end else begin
            vld_pipe <= MC_FIFO_LAT'({vld_pipe, rd_acc});
            if (rd_acc) begin
                rdata_o <= head[rd_ch_i];
                rch_o   <= rd_ch_i;
            end
        end
    end

`ifdef MC_FIFO_ERR_EN
    logic [N_CH-1:0] ovf_set, udf_set;

    assign ovf_set = wr_en & full_vec_o;
    assign udf_set = rd_en & empty_vec_o;

    // Setting beats clearing when both land in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_vec_o <= '0;
            udf_vec_o <= '0;
        end else begin
            ovf_vec_o <= (ovf_vec_o & ~{N_CH{err_clr_i}}) | ovf_set;
            udf_vec_o <= (udf_vec_o & ~{N_CH{err_clr_i}}) | udf_set;
        end
    end
`endif

endmodule

// File: tb/tb_mc_fifo_array.sv
// Scoreboard bench for mc_fifo_array: queue-per-channel model, decoupled read monitor.
module tb_mc_fifo_array;

    typedef struct {
        int          due;
        logic [31:0] d;
        int          ch;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  wr_ch_i = '0, rd_ch_i = '0;
    logic        wren_i = 1'b0, rden_i = 1'b0;
    logic [31:0] wdata_i = '0;
    logic        full_o, empty_o, rvalid_o;
    logic [31:0] rdata_o;
    logic [1:0]  rch_o;
    logic [3:0]  full_vec_o, empty_vec_o, afull_vec_o;
    logic [19:0] cnt_o;
`ifdef MC_FIFO_ERR_EN
    logic        err_clr_i = 1'b0;
    logic [3:0]  ovf_vec_o, udf_vec_o;
    bit   [3:0]  m_ovf = '0, m_udf = '0;
`endif

    logic [31:0] mq[4][$];
    exp_t        exp_q[$];
    int          cyc = 0;
    int          n_pass = 0, n_tot = 0;

    mc_fifo_array dut (
        .clk(clk), .rst(rst),
`ifdef MC_FIFO_ERR_EN
        .err_clr_i(err_clr_i), .ovf_vec_o(ovf_vec_o), .udf_vec_o(udf_vec_o),
`endif
        .wr_ch_i(wr_ch_i), .wren_i(wren_i), .wdata_i(wdata_i), .full_o(full_o),
        .rd_ch_i(rd_ch_i), .rden_i(rden_i), .empty_o(empty_o),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .rch_o(rch_o),
        .full_vec_o(full_vec_o), .empty_vec_o(empty_vec_o),
        .afull_vec_o(afull_vec_o), .cnt_o(cnt_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check_state();
        logic [3:0] ef, ee, ea;
        for (int c = 0; c < 4; c++) begin
            ef[c] = (mq[c].size() == 16);
            ee[c] = (mq[c].size() == 0);
            ea[c] = (mq[c].size() >= 12);
            chk($sformatf("cnt%0d", c), 64'(cnt_o[c*5 +: 5]), 64'(mq[c].size()));
        end
        chk("full_vec", 64'(full_vec_o), 64'(ef));
        chk("empty_vec", 64'(empty_vec_o), 64'(ee));
        chk("afull_vec", 64'(afull_vec_o), 64'(ea));
`ifdef MC_FIFO_ERR_EN
        chk("ovf_vec", 64'(ovf_vec_o), 64'(m_ovf));
        chk("udf_vec", 64'(udf_vec_o), 64'(m_udf));
`endif
    endtask

    // One cycle: called at a negedge, returns at the next negedge.
    task automatic step(input bit we, input int wc, input logic [31:0] wd,
                        input bit re, input int rc);
        bit   wr_ok, rd_ok;
        exp_t e;
        check_state();
        wren_i = we; wr_ch_i = wc[1:0]; wdata_i = wd;
        rden_i = re; rd_ch_i = rc[1:0];
        #1;
        chk("full_o", 64'(full_o), 64'(mq[wc].size() == 16));
        chk("empty_o", 64'(empty_o), 64'(mq[rc].size() == 0));
        wr_ok = we && (mq[wc].size() < 16);
        rd_ok = re && (mq[rc].size() > 0);
        if (rd_ok) begin
            e.due = cyc + 1; e.d = mq[rc].pop_front(); e.ch = rc;
            exp_q.push_back(e);
        end
        if (wr_ok) mq[wc].push_back(wd);
`ifdef MC_FIFO_ERR_EN
        if (err_clr_i) begin m_ovf = '0; m_udf = '0; end
        if (we && !wr_ok) m_ovf[wc] = 1'b1;
        if (re && !rd_ok) m_udf[rc] = 1'b1;
`endif
        @(negedge clk);
        wren_i = 1'b0; rden_i = 1'b0;
    endtask

    // Monitor: every cycle the DUT shows rvalid_o it must match the oldest due expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            if (rvalid_o) begin
                if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
                    chk("rvalid_unexpected", 64'(rvalid_o), 64'(1'b0));
                end else begin
                    e = exp_q.pop_front();
                    chk("rdata", 64'(rdata_o), 64'(e.d));
                    chk("rch", 64'(rch_o), 64'(e.ch));
                end
            end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                chk("rvalid_missing", 64'(rvalid_o), 64'(1'b1));
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_rvalid", 64'(rvalid_o), 64'(1'b0));
        chk("rst_rdata", 64'(rdata_o), 64'(0));
        chk("rst_rch", 64'(rch_o), 64'(0));
        check_state();
        rst = 1'b0;
        @(negedge clk);

        // Fill ch2, then overflow it.
        for (int i = 0; i < 16; i++) step(1, 2, 32'(i), 0, 0);
        step(1, 2, 32'hDEAD, 0, 0);
`ifdef MC_FIFO_ERR_EN
        check_state();
        err_clr_i = 1'b1;
        step(0, 0, 0, 0, 0);
        err_clr_i = 1'b0;
`endif
        // Drain ch2 in order, then one rejected read of the now-empty channel.
        for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 2);
        step(0, 0, 0, 1, 2);

        // Cross-channel write and read in one cycle.
        step(1, 3, 32'h77, 0, 0);
        step(1, 1, 32'hA5, 1, 3);

        // Same-channel collisions on empty and full ch0.
        step(1, 0, 32'h100, 1, 0);
        for (int i = 1; i < 16; i++) step(1, 0, 32'h100 + 32'(i), 0, 0);
        step(1, 0, 32'hBEEF, 1, 0);
        for (int i = 0; i < 15; i++) step(0, 0, 0, 1, 0);

        // Reset with ch1 at 5 entries and a read in flight.
        while (mq[1].size() < 5) step(1, 1, $urandom, 0, 0);
        check_state();
        rden_i = 1'b1; rd_ch_i = 2'd1;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_rvalid", 64'(rvalid_o), 64'(1'b0));
        chk("midrst_rdata", 64'(rdata_o), 64'(0));
        chk("midrst_cnt", 64'(cnt_o), 64'(0));
        chk("midrst_empty", 64'(empty_vec_o), 64'(4'b1111));
        rden_i = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 4; c++) mq[c].delete();
`ifdef MC_FIFO_ERR_EN
        m_ovf = '0; m_udf = '0;
`endif
        #1 rst = 1'b0;
        @(negedge clk);

        // Streaming through ch1 across pointer wrap.
        for (int i = 0; i < 40; i++) step(1, 1, 32'h1000 + 32'(i), i >= 3, 1);

        // Random traffic on all channels.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 99) < 60, $urandom_range(0, 3), $urandom,
                 $urandom_range(0, 99) < 45, $urandom_range(0, 3));

        repeat (3) step(0, 0, 0, 0, 0);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
